// File: rtl/r_instr_loader_pkg.sv
// Shared definitions for the R-format instruction loader: supported opcodes,
// loader FSM state encoding and the opcode legality check.
package r_instr_loader_pkg;

    // Supported R-format opcodes (11 bits).
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_ANDS = 11'b11101010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;

    // Loader FSM states; IDLE is the all-zero reset encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // True when the opcode belongs to the supported R-format set.
    function automatic logic is_legal_op(input logic [10:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR,
            OP_ADDS, OP_SUBS, OP_ANDS, OP_LSL, OP_LSR: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/r_instr_loader_r_encoder.sv
// Combinational R-format encoder: packs {op, rm, shamt, rn, rd} into a 32-bit
// word and flags whether the opcode is supported. Only the shift opcodes carry
// a shift amount; every other opcode gets a zero shamt field.
module r_encoder
    import r_instr_loader_pkg::*;
(
    input  logic [10:0] op_i,
    input  logic [4:0]  rm_i,
    input  logic [5:0]  shamt_i,
    input  logic [4:0]  rn_i,
    input  logic [4:0]  rd_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    logic       is_shift;
    logic [5:0] shamt_eff;

    // LSL/LSR are the only supported opcodes with op[3] and op[1] both set.
    assign is_shift  = op_i[1] & op_i[3];
    assign shamt_eff = is_shift ? shamt_i : 6'b0;
    assign word_o    = {op_i, rm_i, shamt_eff, rn_i, rd_i};
    assign legal_o   = is_legal_op(op_i);

endmodule

// File: rtl/r_instr_loader.sv
// R-format instruction loader: takes field tuples over a valid/ready stream,
// drops unsupported opcodes (flagging err), and writes encoded words to
// consecutive word addresses of instruction memory.
//
// Handshake: a tuple transfers on a rising clock edge where in_valid and
// in_ready are both high; in_ready is high only in LOAD and does not depend
// on in_valid, and the source must hold the tuple stable until it transfers.
module r_instr_loader
    import r_instr_loader_pkg::*;
#(
    parameter int AW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [10:0]      in_op,
    input  logic [4:0]       in_rm,
    input  logic [5:0]       in_shamt,
    input  logic [4:0]       in_rn,
    input  logic [4:0]       in_rd,
    output logic             mem_write,
    output logic [AW-1:0]    mem_addr,
    output logic [31:0]      mem_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       dbg_state
);

    localparam logic [AW-1:0]    ADDR_STEP = AW'(4);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             err_q, err_d;
    logic             wr_q, wr_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [31:0]      mem_data_q, mem_data_d;

    logic [31:0]      enc_word;
    logic             enc_legal;
    logic             accept;

    r_encoder u_enc (
        .op_i    (in_op),
        .rm_i    (in_rm),
        .shamt_i (in_shamt),
        .rn_i    (in_rn),
        .rd_i    (in_rd),
        .word_o  (enc_word),
        .legal_o (enc_legal)
    );

    assign in_ready  = (state_q == ST_LOAD);
    assign accept    = in_valid & in_ready;
    assign mem_write = wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign dbg_state = state_q;

    // Next-state, counter and write-register logic for the load sequence.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        err_d      = err_q;
        wr_d       = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = {base_addr[AW-1:2], 2'b00};
                    rem_d   = count;
                    err_d   = 1'b0;
                    state_d = (count == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (enc_legal) begin
                        wr_d       = 1'b1;
                        mem_addr_d = addr_q;
                        mem_data_d = enc_word;
                        addr_d     = addr_q + ADDR_STEP;
                        rem_d      = rem_q - CNT_ONE;
                        if (rem_q == CNT_ONE) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any load in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            err_q      <= 1'b0;
            wr_q       <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            err_q      <= err_d;
            wr_q       <= wr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

endmodule

// File: tb/tb_r_instr_loader.sv
// Directed bench for r_instr_loader: each scenario task drives a load and
// checks the captured write stream and status outputs against hand-computed
// values.
module tb_r_instr_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] count = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] in_op = '0;
    logic [4:0]  in_rm = '0;
    logic [5:0]  in_shamt = '0;
    logic [4:0]  in_rn = '0;
    logic [4:0]  in_rd = '0;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Observed write stream and status counters.
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          ready_cnt = 0;

    // Expected write stream for the scenario in progress.
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];

    r_instr_loader #(.AW(32), .CNT_W(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rm     (in_rm),
        .in_shamt  (in_shamt),
        .in_rn     (in_rn),
        .in_rd     (in_rd),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter.
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: capture writes, done pulses and ready cycles mid-cycle.
    always @(negedge clock) begin
        if (mem_write) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_data);
            wr_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt  = done_cnt + 1;
            done_cyc  = cyc;
        end
        if (in_ready) ready_cnt = ready_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        exp_q.delete();
        exp_addr_q.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        ready_cnt = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [15:0] c, output int sc);
        base_addr = b;
        count     = c;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        sc    = cyc;
    endtask

    task automatic send(input logic [10:0] op, input logic [4:0] rm, input logic [5:0] sh,
                        input logic [4:0] rn, input logic [4:0] rd);
        int n;
        in_op    = op;
        in_rm    = rm;
        in_shamt = sh;
        in_rn    = rn;
        in_rd    = rd;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clock);
            if (in_ready) begin
                @(posedge clock);
                #1;
                break;
            end
            n++;
            if (n > 20) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got in_ready=0 for %0d cycles want 1", n);
                in_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL done_timeout: got no done within %0d cycles want a pulse", budget);
        end
    endtask

    task automatic check_writes(input string name);
        total++;
        if (wr_addr_q.size() !== exp_addr_q.size()) begin
            bad++;
            $display("FAIL %s_count: got %0d writes want %0d", name, wr_addr_q.size(), exp_addr_q.size());
        end else begin
            for (int i = 0; i < exp_addr_q.size(); i++) begin
                total++;
                if (wr_addr_q[i] !== exp_addr_q[i]) begin
                    bad++;
                    $display("FAIL %s_addr%0d: got %h want %h", name, i, wr_addr_q[i], exp_addr_q[i]);
                end
                total++;
                if (wr_data_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL %s_data%0d: got %h want %h", name, i, wr_data_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        total++;
        if ({in_ready, mem_write, busy, done, err} !== 5'b0 || mem_addr !== 32'h0 || mem_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b wr=%b busy=%b done=%b err=%b addr=%h data=%h want all 0",
                     in_ready, mem_write, busy, done, err, mem_addr, mem_data);
        end
        @(negedge clock);
        reset = 1'b0;
        step();
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b rdy=%b state=%0d want 0 0 0", busy, in_ready, dbg_state);
        end
    endtask

    task automatic test_basic_load();
        int sc;
        clear_mon();
        exp_addr_q = '{32'h100, 32'h104, 32'h108};
        exp_q      = '{32'h8B020023, 32'hCB0500C7, 32'hAA1F0001};
        do_start(32'h100, 16'd3, sc);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy: got %b want 1", busy);
        end
        send(11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd3);
        send(11'b11001011000, 5'd5, 6'd0, 5'd6, 5'd7);
        send(11'b10101010000, 5'd31, 6'd0, 5'd0, 5'd1);
        in_valid = 1'b0;
        wait_done(20);
        repeat (3) step();
        check_writes("basic");
        if (wr_cyc_q.size() == 3) begin
            total++;
            if (wr_cyc_q[0] !== sc + 1) begin
                bad++;
                $display("FAIL basic_first_latency: got cycle %0d want %0d", wr_cyc_q[0], sc + 1);
            end
            total++;
            if (wr_cyc_q[2] - wr_cyc_q[0] !== 2) begin
                bad++;
                $display("FAIL basic_back_to_back: got span %0d want 2", wr_cyc_q[2] - wr_cyc_q[0]);
            end
            total++;
            if (done_cyc !== wr_cyc_q[2] + 1) begin
                bad++;
                $display("FAIL basic_done_timing: got cycle %0d want %0d", done_cyc, wr_cyc_q[2] + 1);
            end
        end
        total++;
        if (done_cnt !== 1 || err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_status: got done_cnt=%0d err=%b busy=%b want 1 0 0", done_cnt, err, busy);
        end
    endtask

    task automatic test_idle_hold();
        clear_mon();
        in_op    = 11'b10001011000;
        in_valid = 1'b1;
        repeat (4) step();
        in_valid = 1'b0;
        total++;
        if (ready_cnt !== 0 || wr_addr_q.size() !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: got ready_cnt=%0d writes=%0d busy=%b want 0 0 0",
                     ready_cnt, wr_addr_q.size(), busy);
        end
    endtask

    task automatic test_shamt();
        int sc;
        clear_mon();
        exp_addr_q = '{32'h200, 32'h204};
        exp_q      = '{32'hD3601486, 32'h8B010043};
        do_start(32'h203, 16'd2, sc);
        send(11'b11010011011, 5'd0, 6'd5, 5'd4, 5'd6);
        send(11'b10001011000, 5'd1, 6'd7, 5'd2, 5'd3);
        in_valid = 1'b0;
        wait_done(20);
        step();
        check_writes("shamt");
        if (wr_data_q.size() == 2) begin
            total++;
            if (wr_data_q[1][15:10] !== 6'b0) begin
                bad++;
                $display("FAIL shamt_add_zero: got %b want 000000", wr_data_q[1][15:10]);
            end
        end
    endtask

    task automatic test_illegal();
        int sc;
        clear_mon();
        exp_addr_q = '{32'h300, 32'h304};
        exp_q      = '{32'h8B000000, 32'h8A030085};
        do_start(32'h300, 16'd2, sc);
        send(11'b10001011000, 5'd0, 6'd0, 5'd0, 5'd0);
        send(11'b11111111111, 5'd9, 6'd9, 5'd9, 5'd9);
        send(11'b10001010000, 5'd3, 6'd0, 5'd4, 5'd5);
        in_valid = 1'b0;
        wait_done(20);
        check_writes("illegal");
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL illegal_err: got %b want 1", err);
        end
        repeat (5) step();
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL illegal_err_sticky: got %b want 1", err);
        end
    endtask

    task automatic test_zero_count();
        int sc;
        clear_mon();
        do_start(32'h500, 16'd0, sc);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL zero_err_cleared: got %b want 0", err);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL zero_done_now: got done=%b busy=%b want 1 1", done, busy);
        end
        repeat (4) step();
        total++;
        if (done_cnt !== 1 || done_cyc !== sc) begin
            bad++;
            $display("FAIL zero_done_pulse: got cnt=%0d cyc=%0d want 1 %0d", done_cnt, done_cyc, sc);
        end
        total++;
        if (wr_addr_q.size() !== 0 || ready_cnt !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_quiet: got writes=%0d ready_cnt=%0d busy=%b want 0 0 0",
                     wr_addr_q.size(), ready_cnt, busy);
        end
    endtask

    task automatic test_wrap();
        int sc;
        clear_mon();
        exp_addr_q = '{32'hFFFFFFFC, 32'h00000000};
        exp_q      = '{32'hCA010021, 32'hD3400C49};
        do_start(32'hFFFFFFFC, 16'd2, sc);
        send(11'b11001010000, 5'd1, 6'd0, 5'd1, 5'd1);
        send(11'b11010011010, 5'd0, 6'd3, 5'd2, 5'd9);
        in_valid = 1'b0;
        wait_done(20);
        step();
        check_writes("wrap");
    endtask

    task automatic test_restart_and_reset();
        int sc;
        clear_mon();
        exp_addr_q = '{32'h400, 32'h404};
        exp_q      = '{32'hEB010021, 32'h8B020023};
        do_start(32'h400, 16'd4, sc);
        send(11'b11101011000, 5'd1, 6'd0, 5'd1, 5'd1);
        in_valid = 1'b0;
        step();
        base_addr = 32'h800;
        count     = 16'd1;
        start     = 1'b1;
        step();
        start = 1'b0;
        send(11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd3);
        in_valid = 1'b0;
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        total++;
        if ({in_ready, mem_write, busy, done, err} !== 5'b0 || mem_addr !== 32'h0 || mem_data !== 32'h0) begin
            bad++;
            $display("FAIL midload_reset: got rdy=%b wr=%b busy=%b done=%b err=%b addr=%h data=%h want all 0",
                     in_ready, mem_write, busy, done, err, mem_addr, mem_data);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset     = 1'b0;
        ready_cnt = 0;
        in_op     = 11'b10001011000;
        in_valid  = 1'b1;
        repeat (5) step();
        in_valid = 1'b0;
        check_writes("restart");
        total++;
        if (ready_cnt !== 0 || busy !== 1'b0 || done_cnt !== 0) begin
            bad++;
            $display("FAIL after_reset_quiet: got ready_cnt=%0d busy=%b done_cnt=%0d want 0 0 0",
                     ready_cnt, busy, done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_idle_hold();
        test_shamt();
        test_illegal();
        test_zero_count();
        test_wrap();
        test_restart_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
